// File: rtl/tri_mode_ethernet_mac_tx_fifo.sv
// Store-and-forward TX frame FIFO feeding the tri-mode MAC: frames become readable only once committed.
// Optional statistics ports are enabled by defining TX_FIFO_STATS_EN.
module tri_mode_ethernet_mac_tx_fifo #(
    parameter int C_ADDR_WIDTH = 11,
    parameter int C_MAX_FRAMES = 32
) (
    input  logic        tx_mac_aclk,
    input  logic        tx_mac_reset,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tuser,
    output logic        s_axis_tready,
    output logic [7:0]  tx_axis_mac_tdata,
    output logic        tx_axis_mac_tvalid,
    output logic        tx_axis_mac_tlast,
    input  logic        tx_axis_mac_tready
`ifdef TX_FIFO_STATS_EN
   ,output logic [15:0] tx_fifo_drop_cnt,
    output logic [15:0] tx_fifo_frame_cnt,
    output logic        tx_fifo_overflow
`endif
);

    localparam int PTR_W = C_ADDR_WIDTH + 1;
    localparam int CNT_W = $clog2(C_MAX_FRAMES + 1);
    localparam logic [PTR_W-1:0] DEPTH   = {1'b1, {C_ADDR_WIDTH{1'b0}}};
    localparam logic [PTR_W-1:0] PTR_ONE = {{C_ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(C_MAX_FRAMES);

    typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_DROP} wr_state_t;
    typedef enum logic [1:0] {RD_IDLE, RD_FETCH, RD_SEND} rd_state_t;

    logic [8:0]       mem [0:2**C_ADDR_WIDTH-1];
    wr_state_t        wr_state, wr_state_nxt;
    rd_state_t        rd_state, rd_state_nxt;
    logic [PTR_W-1:0] wr_ptr, wr_ptr_nxt, cmt_ptr, cmt_ptr_nxt, rd_ptr;
    logic [PTR_W-1:0] frame_len, fill;
    logic [CNT_W-1:0] frame_cnt, frame_cnt_nxt;
    logic             full, s_ready, wr_hs, mem_we, commit;
    logic [8:0]       mem_word;
    logic             out_valid, out_last, pf_valid, pf_last, last_issued;
    logic [7:0]       out_data, pf_data;
    logic             pop, out_free, rd_en, rd_done;

    assign frame_len = wr_ptr - cmt_ptr;
    assign fill      = wr_ptr - rd_ptr;
    assign full      = (fill == DEPTH);
    // An oversize frame keeps tready high so the user is never stalled while it is discarded.
    assign s_ready   = (wr_state == WR_DROP) ||
                       ((frame_cnt != CNT_MAX) && !(full && (frame_len < DEPTH)));
    assign wr_hs     = s_axis_tvalid && s_ready;

    always_comb begin
        wr_state_nxt = wr_state;
        wr_ptr_nxt   = wr_ptr;
        cmt_ptr_nxt  = cmt_ptr;
        mem_we       = 1'b0;
        commit       = 1'b0;
        case (wr_state)
            WR_IDLE, WR_DATA: begin
                if (wr_hs) begin
                    if (full) begin
                        wr_ptr_nxt   = cmt_ptr;
                        wr_state_nxt = s_axis_tlast ? WR_IDLE : WR_DROP;
                    end else begin
                        mem_we = 1'b1;
                        if (s_axis_tlast) begin
                            wr_state_nxt = WR_IDLE;
                            if (s_axis_tuser) begin
                                wr_ptr_nxt = cmt_ptr;
                            end else begin
                                wr_ptr_nxt  = wr_ptr + PTR_ONE;
                                cmt_ptr_nxt = wr_ptr + PTR_ONE;
                                commit      = 1'b1;
                            end
                        end else begin
                            wr_ptr_nxt   = wr_ptr + PTR_ONE;
                            wr_state_nxt = WR_DATA;
                        end
                    end
                end
            end
            WR_DROP: begin
                if (wr_hs && s_axis_tlast) wr_state_nxt = WR_IDLE;
            end
            default: wr_state_nxt = WR_IDLE;
        endcase
    end

    // NOTE: the storage array has no reset; the pointers alone define which entries are meaningful.
    always_ff @(posedge tx_mac_aclk) begin
        if (mem_we) mem[wr_ptr[C_ADDR_WIDTH-1:0]] <= {s_axis_tlast, s_axis_tdata};
    end

    assign mem_word = mem[rd_ptr[C_ADDR_WIDTH-1:0]];
    assign pop      = out_valid && tx_axis_mac_tready;
    assign rd_done  = pop && out_last;
    assign out_free = pop || !out_valid;

    // Reads stop once the frame's tlast word is fetched, so the reader never passes cmt_ptr.
    always_comb begin
        rd_en        = 1'b0;
        rd_state_nxt = rd_state;
        case (rd_state)
            RD_IDLE:  if (frame_cnt != '0) rd_state_nxt = RD_FETCH;
            RD_FETCH: begin
                rd_en        = 1'b1;
                rd_state_nxt = RD_SEND;
            end
            RD_SEND: begin
                rd_en = !last_issued && (!pf_valid || pop);
                if (rd_done) rd_state_nxt = (frame_cnt_nxt != '0) ? RD_FETCH : RD_IDLE;
            end
            default: rd_state_nxt = RD_IDLE;
        endcase
    end

    always_comb begin
        frame_cnt_nxt = frame_cnt;
        if (commit && !rd_done)      frame_cnt_nxt = frame_cnt + CNT_ONE;
        else if (!commit && rd_done) frame_cnt_nxt = frame_cnt - CNT_ONE;
    end

    // NOTE: all state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge tx_mac_aclk or posedge tx_mac_reset) begin
        if (tx_mac_reset) begin
            wr_state  <= WR_IDLE;
            rd_state  <= RD_IDLE;
            wr_ptr    <= '0;
            cmt_ptr   <= '0;
            rd_ptr    <= '0;
            frame_cnt <= '0;
        end else begin
            wr_state  <= wr_state_nxt;
            rd_state  <= rd_state_nxt;
            wr_ptr    <= wr_ptr_nxt;
            cmt_ptr   <= cmt_ptr_nxt;
            frame_cnt <= frame_cnt_nxt;
            if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Output register plus one prefetch slot; the output only changes when it is free or accepted.
    always_ff @(posedge tx_mac_aclk or posedge tx_mac_reset) begin
        if (tx_mac_reset) begin
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            out_data    <= 8'h00;
            pf_valid    <= 1'b0;
            pf_last     <= 1'b0;
            pf_data     <= 8'h00;
            last_issued <= 1'b0;
        end else begin
            if (rd_state == RD_FETCH)       last_issued <= mem_word[8];
            else if (rd_en && mem_word[8])  last_issued <= 1'b1;
            if (out_free && pf_valid) begin
                out_valid <= 1'b1;
                {out_last, out_data} <= {pf_last, pf_data};
                pf_valid <= rd_en;
                if (rd_en) {pf_last, pf_data} <= mem_word;
            end else if (out_free) begin
                out_valid <= rd_en;
                if (rd_en) {out_last, out_data} <= mem_word;
                else       out_last <= 1'b0;
            end else if (rd_en) begin
                pf_valid <= 1'b1;
                {pf_last, pf_data} <= mem_word;
            end
        end
    end

    assign s_axis_tready      = s_ready;
    assign tx_axis_mac_tdata  = out_data;
    assign tx_axis_mac_tvalid = out_valid;
    assign tx_axis_mac_tlast  = out_last;

`ifdef TX_FIFO_STATS_EN
    logic drop_evt, ovf_evt;
    assign ovf_evt  = wr_hs && full && (wr_state != WR_DROP);
    assign drop_evt = wr_hs && s_axis_tlast && ((wr_state == WR_DROP) || full || s_axis_tuser);

    always_ff @(posedge tx_mac_aclk or posedge tx_mac_reset) begin
        if (tx_mac_reset) begin
            tx_fifo_drop_cnt  <= 16'h0000;
            tx_fifo_frame_cnt <= 16'h0000;
            tx_fifo_overflow  <= 1'b0;
        end else begin
            tx_fifo_overflow <= ovf_evt;
            if (drop_evt && (tx_fifo_drop_cnt != 16'hFFFF))
                tx_fifo_drop_cnt <= tx_fifo_drop_cnt + 16'd1;
            if (rd_done && (tx_fifo_frame_cnt != 16'hFFFF))
                tx_fifo_frame_cnt <= tx_fifo_frame_cnt + 16'd1;
        end
    end
`endif

endmodule
